vga_rx_monitor: RTL
===================

# vga_rx_monitor

Receive-side VGA timing monitor and pixel recovery block. It sits on the same `hsync`/`vsync`/RGB332 bus that the game's 640x480 raster generator drives. It recovers column/row position from the sync edges, checks every line and frame against the 640x480@60 timing constants, and declares lock after clean frames. While locked it streams active pixels with coordinates, for board loopback self-test and for testbench scoreboarding.

## Interface
- `HPIXELS`, 800, pixel clocks per line
- `VLINES`, 521, lines per frame
- `HPULSE`, 96, hsync low width in pixels
- `VPULSE`, 2, vsync low width in lines
- `HBP` / `HFP`, 144 / 784, first active column / first column past active
- `VBP` / `VFP`, 31 / 511, first active row / first row past active
- `LOCK_FRAMES`, 2, consecutive clean frames required to lock
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  reset, synchronous, active-high
- `pix_en`  in  1  one-clk strobe, 25 MHz; all bus sampling happens only on these cycles
- `hsync`, `vsync`  in  1 each  active-low syncs
- `red` / `green` / `blue`  in  3/3/2  pixel colour
- `err_clr`  in  1  clears `err_flags` and `err_cnt`
- `locked`  out  1  timing lock
- `pix_valid`  out  1  one-clk pulse per active pixel while locked
- `pix_x`  out  10  active column, 0..639
- `pix_y`  out  9  active row, 0..479
- `pix_rgb`  out  8  {red,green,blue}
- `frame_done`  out  1  one-clk pulse at each frame boundary while locked
- `frame_sum`  out  16  checksum of the completed frame
- `err_flags`  out  4  sticky flags {vpulse, vlen, hpulse, hlen}
- `err_cnt`  out  8  saturating count of frames that had an error

## Operation
- Each `pix_en` cycle samples hsync, vsync and RGB, and keeps the previous sync samples.
- An edge is a 1→0 or 0→1 change between consecutive samples.
- Column counter `col` (10 b):
  - on an hsync falling edge, `col` = 0;
  - otherwise `col` increments, saturating at 1023.
- Row counter `row` (10 b):
  - on a vsync falling edge, `row` = 0, taking precedence over the hsync fall in the same sample;
  - otherwise `row` increments on each hsync falling edge.
- Error checks:
  - hlen: at an hsync fall, previous `col` ≠ HPIXELS−1, or `col` reaches 2·HPIXELS with no hsync fall;
  - hpulse: at an hsync rise, `col` ≠ HPULSE;
  - vlen: at a vsync fall, previous `row` ≠ VLINES−1;
  - vpulse: at a vsync rise, `row` ≠ VPULSE or `col` ≠ 0.
- A check fires only after the first vsync fall has been seen (state ≠ SEARCH). The first hsync fall after SEARCH is exempt from hlen.
- States:
  - SEARCH: wait for a vsync fall, then go to TRACK with `good` = 0.
  - TRACK: at each vsync fall, a frame with no error gives `good`+1, otherwise `good` = 0. When `good` reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: any error clears `locked` immediately and goes to TRACK with `good` = 0.
  - Any state: the hlen timeout (no hsync fall) goes to SEARCH.
- On any check firing, the matching `err_flags` bit sets. `err_cnt` increments at most once per frame, at the vsync fall that closes a frame containing an error, and saturates at 255.
- `err_clr` clears flags and count in the same cycle. A flag set in that same cycle wins.
- Active pixel: HBP ≤ `col` < HFP and VBP ≤ `row` < VFP. While LOCKED, `pix_valid` pulses with `pix_x` = `col`−HBP, `pix_y` = `row`−VBP and `pix_rgb` = the sample.
- `frame_done` pulses at a vsync fall that is seen in LOCKED or causes entry to LOCKED, provided that frame had no error.

## Timing
- All outputs are registered. `pix_*`, `frame_done`, `locked` and `err_*` update exactly 1 clk after the `pix_en` cycle whose sample caused them.
- Reset value of every output is 0. Internal counters also reset to 0 and the state resets to SEARCH.
- `pix_x`/`pix_y`/`pix_rgb` hold their values between pulses.
- With a nominal source, `locked` rises 1 clk after the vsync-fall sample that ends frame LOCK_FRAMES after the first observed vsync fall.
- `rst` mid-frame discards all state. Relock requires a fresh vsync fall plus LOCK_FRAMES clean frames.

## Configuration
- `VGA_RX_CHECKSUM_EN` defined:
  - a 16-bit accumulator adds `pix_rgb` (zero-extended) for every active pixel, modulo 2^16;
  - at each vsync fall the sum is latched into `frame_sum` and the accumulator is cleared.
- Undefined: no accumulator is built and `frame_sum` is constant 0.

## Test plan
- Nominal 640x480 source from reset: `locked` = 0 through frames 0–1, then rises 1 clk after the third vsync-fall sample. Exactly 307200 `pix_valid` pulses per locked frame. The first pulse has x=0,y=0; the last has x=639,y=479.
- Constant RGB 0xFF, checksum enabled: every locked `frame_done` has `frame_sum` = 0x5000. With the macro undefined, `frame_sum` = 0.
- While locked, one line stretched to 801 pixels: `err_flags`[0] sets, `locked` drops 1 clk after that hsync-fall sample, and `err_cnt` = 1 at the frame end. Relock occurs two clean frames later.
- vsync pulse 3 lines: `err_flags`[3] sets and `err_cnt` increments. `err_clr` then returns flags and count to 0.
- hsync held high for 1600 pixel clocks: `err_flags`[0] sets, state returns to SEARCH, and no `pix_valid` pulses occur until relock.
- `rst` asserted mid-frame while locked: all outputs 0 the next clk, and lock is reacquired only after a vsync fall plus 2 clean frames.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// Receive-side VGA timing monitor: recovers raster position from the sync edges,
// checks line/frame timing, locks after clean frames and streams active pixels.
// Optional per-frame pixel checksum is built when VGA_RX_CHECKSUM_EN is defined.
module vga_rx_monitor #(
    parameter int HPIXELS     = 800,
    parameter int VLINES      = 521,
    parameter int HPULSE      = 96,
    parameter int VPULSE      = 2,
    parameter int HBP         = 144,
    parameter int HFP         = 784,
    parameter int VBP         = 31,
    parameter int VFP         = 511,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [1:0]  blue,
    input  logic        err_clr,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [7:0]  pix_rgb,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [3:0]  err_flags,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    // The 10-bit column counter saturates at 1023, so a timeout beyond that is clamped.
    localparam int TMO = (2 * HPIXELS > 1023) ? 1023 : 2 * HPIXELS;

    localparam logic [9:0]    TMO_PRE  = 10'(TMO - 1);
    localparam logic [9:0]    HLAST    = 10'(HPIXELS - 1);
    localparam logic [9:0]    HPULSE_C = 10'(HPULSE);
    localparam logic [9:0]    VLAST    = 10'(VLINES - 1);
    localparam logic [9:0]    VPULSE_C = 10'(VPULSE);
    localparam logic [9:0]    HBP_C    = 10'(HBP);
    localparam logic [9:0]    HFP_C    = 10'(HFP);
    localparam logic [9:0]    VBP_C    = 10'(VBP);
    localparam logic [9:0]    VFP_C    = 10'(VFP);
    localparam logic [GW-1:0] LOCK_C   = GW'(LOCK_FRAMES);

    state_t        state;
    state_t        state_next;
    logic [GW-1:0] good;
    logic [GW-1:0] good_next;
    logic [GW-1:0] good_inc;

    logic       hs_prev;
    logic       vs_prev;
    logic [9:0] col;
    logic [9:0] row;
    logic [9:0] col_next;
    logic [9:0] row_next;
    logic       exempt;
    logic       frame_err;

    logic       hs_fall;
    logic       hs_rise;
    logic       vs_fall;
    logic       vs_rise;
    logic       checking;
    logic       timeout;
    logic [3:0] err_now;
    logic       any_err;
    logic       frame_bad;
    logic       active;

    logic       locked_d;
    logic       pix_valid_d;
    logic       frame_done_d;
    logic       err_inc;

    always_comb begin
        hs_fall  = pix_en & hs_prev & ~hsync;
        hs_rise  = pix_en & ~hs_prev & hsync;
        vs_fall  = pix_en & vs_prev & ~vsync;
        vs_rise  = pix_en & ~vs_prev & vsync;
        checking = (state != SEARCH);

        col_next = col;
        if (hs_fall)
            col_next = '0;
        else if (col != 10'h3FF)
            col_next = col + 10'd1;

        row_next = row;
        if (vs_fall)
            row_next = '0;
        else if (hs_fall && row != 10'h3FF)
            row_next = row + 10'd1;

        timeout    = checking & pix_en & ~hs_fall & (col == TMO_PRE);
        err_now[0] = checking & ((hs_fall & ~exempt & (col != HLAST)) | timeout);
        err_now[1] = checking & hs_rise & (col_next != HPULSE_C);
        err_now[2] = checking & vs_fall & (row != VLAST);
        err_now[3] = checking & vs_rise & ((row_next != VPULSE_C) | (col_next != 10'd0));
        any_err    = |err_now;
        frame_bad  = frame_err | any_err;

        active = (col_next >= HBP_C) && (col_next < HFP_C) &&
                 (row_next >= VBP_C) && (row_next < VFP_C);
        good_inc = good + GW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_next;
            good  <= good_next;
        end
    end

    // Lock progress is judged at each vsync fall; the hsync timeout overrides everything.
    always_comb begin
        state_next = state;
        good_next  = good;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_next = TRACK;
                    good_next  = '0;
                end
            end
            TRACK: begin
                if (vs_fall) begin
                    if (frame_bad) begin
                        good_next = '0;
                    end else if (good_inc == LOCK_C) begin
                        state_next = LOCKED;
                        good_next  = good_inc;
                    end else begin
                        good_next = good_inc;
                    end
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_next = TRACK;
                    good_next  = '0;
                end
            end
            default: begin
                state_next = SEARCH;
                good_next  = '0;
            end
        endcase
        if (timeout) begin
            state_next = SEARCH;
            good_next  = '0;
        end
    end

    always_comb begin
        locked_d     = (state_next == LOCKED);
        pix_valid_d  = pix_en & active & locked_d;
        frame_done_d = vs_fall & ~frame_bad & locked_d;
        err_inc      = vs_fall & frame_bad;
    end

    // Sync samples idle high so the first low sample after reset reads as a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev    <= 1'b1;
            vs_prev    <= 1'b1;
            col        <= '0;
            row        <= '0;
            exempt     <= 1'b0;
            frame_err  <= 1'b0;
            locked     <= 1'b0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_rgb    <= '0;
            err_flags  <= '0;
            err_cnt    <= '0;
        end else begin
            locked     <= locked_d;
            pix_valid  <= pix_valid_d;
            frame_done <= frame_done_d;
            err_flags  <= (err_clr ? 4'd0 : err_flags) | err_now;
            if (err_clr)
                err_cnt <= err_inc ? 8'd1 : 8'd0;
            else if (err_inc && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (pix_en) begin
                hs_prev   <= hsync;
                vs_prev   <= vsync;
                col       <= col_next;
                row       <= row_next;
                exempt    <= (state == SEARCH) ? 1'b1 : (hs_fall ? 1'b0 : exempt);
                frame_err <= vs_fall ? 1'b0 : (frame_err | any_err);
            end
            if (pix_valid_d) begin
                pix_x   <= col_next - HBP_C;
                pix_y   <= 9'(row_next - VBP_C);
                pix_rgb <= {red, green, blue};
            end
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] acc;

    // The pixel sampled at the vsync fall already belongs to the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            frame_sum <= '0;
        end else if (pix_en) begin
            if (vs_fall) begin
                frame_sum <= acc;
                acc       <= active ? {8'd0, red, green, blue} : 16'd0;
            end else if (active) begin
                acc <= acc + {8'd0, red, green, blue};
            end
        end
    end
`else
    assign frame_sum = 16'd0;
`endif

endmodule
